pfifo_gearbox: RTL and testbench
================================

// Module: pfifo_gearbox
// PURPOSE
// - Parametrised byte-granular packing FIFO (gearbox). Each join writes a variable number of bytes;
//   each pop reads a variable number of bytes, independently of the join size.
// - Sits between the upstream byte producer (JoinEnable/JoinPermit) and the downstream consumer
//   (PopEnable/PopPermit) in the receive core-clock domain.
// - Extends the fixed 32-lane PFIFORM with:
//   - parametric lanes and depth
//   - flush of partial residue with last marker
//   - level output
//   - overflow/illegal-amount error
// PARAMETERS
// - LANES          32        bytes per JoinData/PopData word (data width = 8*LANES)
// - DEPTH_BYTES    128       byte storage; power of two, >= 2*LANES
// - PERMIT_MARGIN  3*LANES   free bytes required for JoinPermit=1 (covers 2-cycle upstream enable pipe)
// - AMT_W          $clog2(LANES+1)  width of amount/count ports
// PORTS
// - i_core_clk   in   1              core clock, all logic on rising edge
// - i_rx_rstn    in   1              asynchronous active-low reset
// - JoinEnable   in   1              join strobe; JoinData/JoinAmout valid this cycle
// - JoinAmout    in   AMT_W          bytes to append, 0..LANES
// - JoinData     in   8*LANES        byte k = [8k+7:8k]; byte0 is the oldest; bytes >= JoinAmout ignored
// - JoinPermit   out  1              registered; 1 = upstream may issue joins
// - PopPermit    in   1              consumer ready for a pop
// - PopAmout     in   AMT_W          bytes per pop, 1..LANES (0 = no pop)
// - i_flush      in   1              1-cycle pulse: drain residue smaller than PopAmout
// - PopEnable    out  1              registered; PopData/PopCount valid
// - PopData      out  8*LANES        byte0 = oldest byte; bytes >= PopCount driven 0
// - PopCount     out  AMT_W          bytes carried by this pop
// - PopLast      out  1              pop is the final flush residue
// - Level        out  $clog2(DEPTH_BYTES+1)  stored byte count (registered)
// - OverflowErr  out  1              1-cycle pulse: join dropped
// BEHAVIOUR
// - Reset (async, i_rx_rstn=0):
//   - rd/wr pointers = 0, Level = 0, PopEnable/PopLast/OverflowErr = 0
//   - PopData = 0, PopCount = 0, flush_pend = 0
//   - JoinPermit = 0; it rises 1 cycle after reset release
//   - A reset mid-operation discards all stored bytes.
// - Storage: circular byte array; pointers wrap modulo DEPTH_BYTES. A join writes bytes
//   wr..wr+JoinAmout-1 (mod depth).
// - Join legality:
//   - Legal if JoinAmout <= LANES and JoinAmout <= free bytes (DEPTH_BYTES - Level).
//   - Otherwise the whole join is dropped: no partial write, OverflowErr=1 next cycle.
//   - JoinAmout = 0 is a no-op with no error.
// - Pop decision (cycle t), evaluated on the Level registered at t:
//   - Normal: PopPermit=1, PopAmout != 0, Level >= PopAmout.
//     -> at t+1: PopEnable=1, PopCount=PopAmout, PopLast=0.
//   - Flush: flush_pend=1, PopPermit=1, 0 < Level < PopAmout.
//     -> at t+1: PopEnable=1, PopCount=Level, PopLast=1; flush_pend clears.
//   - PopAmout > LANES is clamped to LANES.
// - Pop latency: 1 cycle. Bytes are removed at the same edge PopData is registered.
//   PopEnable is high for exactly one cycle per pop; back-to-back pops are allowed every cycle.
// - Simultaneous join + pop: Level_next = Level + join_bytes - pop_bytes.
//   - Bytes joined at t are not poppable until t+1.
//   - Free space for the join check is computed from Level at t only; pop freeing in the
//     same cycle is not credited.
// - Flush:
//   - i_flush sets flush_pend.
//   - flush_pend also clears if Level = 0 at the edge following the pulse.
//   - Normal pops take priority while Level >= PopAmout; the residue pop follows.
//   - Joins during flush_pend are accepted and are included in a later normal pop if
//     Level reaches PopAmout.
// - JoinPermit = (DEPTH_BYTES - Level_next) >= PERMIT_MARGIN, registered.
//   - Upstream may still issue up to 2 joins after JoinPermit falls; the margin guarantees
//     these fit at max amount.
// - Level saturates nowhere: legality rules keep it in 0..DEPTH_BYTES.
//   Full (Level = DEPTH_BYTES) and empty (Level = 0) are both reachable.
// TESTING
// - Reset release, 10 joins of 10 bytes (values 0..99), PopAmout=19, PopPermit=1
//   -> 5 pops; first PopData bytes 0..18; bytes 19..31 = 0; Level ends at 5.
// - Then pulse i_flush -> one pop, PopCount=5, PopLast=1, bytes 95..99; Level=0; PopEnable low afterwards.
// - PopPermit=0, joins of 32 bytes until JoinPermit=0
//   -> JoinPermit falls when Level=64; 2 in-flight joins give Level=128; OverflowErr=0.
// - Level=120, JoinAmout=10
//   -> join dropped, OverflowErr=1 for one cycle, Level stays 120.
// - JoinAmout=23 and PopAmout=15 concurrent every cycle for 200 cycles
//   -> output byte stream is strictly sequential mod 256, across pointer wrap; no gaps or duplicates.
// - Assert reset mid-stream with Level=77
//   -> all outputs take reset values immediately; after release, the first pop returns only
//      post-reset data.

Source files
------------

// File: rtl/pfifo_gearbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pfifo_gearbox : byte-granular packing FIFO, variable join and pop sizes.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pfifo_gearbox #(
  parameter int LANES         = 32,
  parameter int DEPTH_BYTES   = 128,
  parameter int PERMIT_MARGIN = 3*LANES,
  parameter int AMT_W         = $clog2(LANES+1),
  parameter int LVL_W         = $clog2(DEPTH_BYTES+1)
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rstn,
  input  logic                 JoinEnable,
  input  logic [AMT_W-1:0]     JoinAmout,
  input  logic [8*LANES-1:0]   JoinData,
  output logic                 JoinPermit,
  input  logic                 PopPermit,
  input  logic [AMT_W-1:0]     PopAmout,
  input  logic                 i_flush,
  output logic                 PopEnable,
  output logic [8*LANES-1:0]   PopData,
  output logic [AMT_W-1:0]     PopCount,
  output logic                 PopLast,
  output logic [LVL_W-1:0]     Level,
  output logic                 OverflowErr
);
  localparam int               c_PTR_W   = $clog2(DEPTH_BYTES);
  localparam int               c_PAD_W   = LVL_W - AMT_W;
  localparam logic [AMT_W-1:0] c_LANES_A = AMT_W'(LANES);
  localparam logic [LVL_W-1:0] c_DEPTH_L = LVL_W'(DEPTH_BYTES);
  localparam logic [LVL_W-1:0] c_MARGIN  = LVL_W'(PERMIT_MARGIN);

  logic [7:0]         r_mem [DEPTH_BYTES];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_flush_pend;
  logic               r_pop_en, r_pop_last, r_ovf, r_permit;
  logic [8*LANES-1:0] r_pop_data;
  logic [AMT_W-1:0]   r_pop_cnt;

  logic [LVL_W-1:0]   w_free, w_join_l, w_pop_amt_l, w_pop_bytes_l, w_level_next;
  logic [AMT_W-1:0]   w_pop_amt, w_pop_cnt;
  logic               w_join_nz, w_join_ok, w_join_bad, w_pop_norm, w_pop_flush;
  logic [8*LANES-1:0] w_pop_data;

  // Free space is taken from the registered level only; a same-cycle pop is not credited.
  always_comb begin
    w_free        = c_DEPTH_L - r_level;
    w_join_l      = {{c_PAD_W{1'b0}}, JoinAmout};
    w_join_nz     = JoinEnable && (JoinAmout != '0);
    w_join_ok     = w_join_nz && (JoinAmout <= c_LANES_A) && (w_join_l <= w_free);
    w_join_bad    = w_join_nz && !w_join_ok;
    w_pop_amt     = (PopAmout > c_LANES_A) ? c_LANES_A : PopAmout;
    w_pop_amt_l   = {{c_PAD_W{1'b0}}, w_pop_amt};
    w_pop_norm    = PopPermit && (w_pop_amt != '0) && (r_level >= w_pop_amt_l);
    w_pop_flush   = r_flush_pend && PopPermit && (r_level != '0) && (r_level < w_pop_amt_l);
    w_pop_cnt     = '0;
    if (w_pop_norm)
      w_pop_cnt = w_pop_amt;
    else if (w_pop_flush)
      w_pop_cnt = r_level[AMT_W-1:0];
    w_pop_bytes_l = {{c_PAD_W{1'b0}}, w_pop_cnt};
    w_level_next  = r_level + (w_join_ok ? w_join_l : '0) - w_pop_bytes_l;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [c_PTR_W-1:0] w_rd_idx;
    assign w_rd_idx = r_rd_ptr + c_PTR_W'(k);
    assign w_pop_data[8*k +: 8] = (AMT_W'(k) < w_pop_cnt) ? r_mem[w_rd_idx] : 8'h00;
  end

  always_ff @(posedge i_core_clk) begin
    if (w_join_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (AMT_W'(k) < JoinAmout)
          r_mem[r_wr_ptr + c_PTR_W'(k)] <= JoinData[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_flush_pend <= 1'b0;
      r_pop_en     <= 1'b0;
      r_pop_data   <= '0;
      r_pop_cnt    <= '0;
      r_pop_last   <= 1'b0;
      r_ovf        <= 1'b0;
      r_permit     <= 1'b0;
    end else begin
      if (w_join_ok)
        r_wr_ptr <= r_wr_ptr + w_join_l[c_PTR_W-1:0];
      r_rd_ptr   <= r_rd_ptr + w_pop_bytes_l[c_PTR_W-1:0];
      r_level    <= w_level_next;
      r_pop_en   <= w_pop_norm || w_pop_flush;
      r_pop_data <= w_pop_data;
      r_pop_cnt  <= w_pop_cnt;
      r_pop_last <= w_pop_flush && !w_pop_norm;
      r_ovf      <= w_join_bad;
      r_permit   <= (c_DEPTH_L - w_level_next) >= c_MARGIN;
      // A pending flush retires with its residue pop, or when nothing is left to drain.
      if (w_pop_flush || (r_flush_pend && (r_level == '0)))
        r_flush_pend <= 1'b0;
      if (i_flush)
        r_flush_pend <= 1'b1;
    end
  end

  assign JoinPermit  = r_permit;
  assign PopEnable   = r_pop_en;
  assign PopData     = r_pop_data;
  assign PopCount    = r_pop_cnt;
  assign PopLast     = r_pop_last;
  assign Level       = r_level;
  assign OverflowErr = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pfifo_gearbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pfifo_gearbox : self-checking bench with byte scoreboard for the gearbox.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pfifo_gearbox;
  localparam int LANES = 32;
  localparam int AMT_W = 6;
  localparam int LVL_W = 8;

  logic               tb_sclk = 1'b0;
  logic               rst_n;
  logic               join_en;
  logic [AMT_W-1:0]   join_amt;
  logic [8*LANES-1:0] join_data;
  logic               join_permit;
  logic               pop_permit;
  logic [AMT_W-1:0]   pop_amt;
  logic               flush;
  logic               pop_en;
  logic [8*LANES-1:0] pop_data;
  logic [AMT_W-1:0]   pop_count;
  logic               pop_last;
  logic [LVL_W-1:0]   level;
  logic               ovf_err;

  int                 n_vec = 0;
  int                 n_err = 0;
  int                 n_pops = 0;
  logic [7:0]         next_byte = 8'h00;
  logic [7:0]         sb_q[$];

  typedef struct {
    bit jen; int jamt; int pamt; bit pperm; bit fl;
    int e_level; bit e_pe; int e_cnt; bit e_last; bit e_ovf; bit e_permit;
  } vec_t;
  vec_t vt[15];

  pfifo_gearbox dut (
    .i_core_clk (tb_sclk),
    .i_rx_rstn  (rst_n),
    .JoinEnable (join_en),
    .JoinAmout  (join_amt),
    .JoinData   (join_data),
    .JoinPermit (join_permit),
    .PopPermit  (pop_permit),
    .PopAmout   (pop_amt),
    .i_flush    (flush),
    .PopEnable  (pop_en),
    .PopData    (pop_data),
    .PopCount   (pop_count),
    .PopLast    (pop_last),
    .Level      (level),
    .OverflowErr(ovf_err)
  );

  always #5 tb_sclk = ~tb_sclk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bytes below amt come from the running counter; the rest are junk the DUT must ignore.
  task automatic drive_join(input int amt, input bit push);
    join_en  = (amt != 0);
    join_amt = AMT_W'(amt);
    for (int k = 0; k < LANES; k++)
      join_data[8*k +: 8] = (k < amt) ? next_byte + 8'(k) : 8'hAA;
    if (push && amt != 0) begin
      for (int k = 0; k < amt; k++) sb_q.push_back(next_byte + 8'(k));
      next_byte = next_byte + 8'(amt);
    end
  endtask

  // Scoreboard monitor: every pop must carry the next queued bytes and zero padding.
  always @(negedge tb_sclk) begin
    if (rst_n && pop_en) begin
      logic [255:0] exp_v;
      exp_v = '0;
      n_pops++;
      for (int k = 0; k < LANES; k++) begin
        if (k < int'(pop_count)) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL pop underrun: pop_count %0d with empty scoreboard", pop_count);
            break;
          end
          exp_v[8*k +: 8] = sb_q.pop_front();
        end
      end
      check("pop data", pop_data, exp_v);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pops0, ovf_seen, waited;
    for (int i = 0; i < 10; i++) begin
      int lv[10] = '{10, 20, 11, 21, 12, 22, 13, 23, 14, 24};
      vt[i] = '{1, 10, 19, 1, 0, lv[i], (i % 2 == 0) && (i > 0), ((i % 2 == 0) && (i > 0)) ? 19 : 0, 0, 0, 1};
    end
    vt[10] = '{0, 0, 19, 1, 0, 5, 1, 19, 0, 0, 1};
    vt[11] = '{0, 0, 19, 1, 0, 5, 0, 0,  0, 0, 1};
    vt[12] = '{0, 0, 19, 1, 1, 5, 0, 0,  0, 0, 1};
    vt[13] = '{0, 0, 19, 1, 0, 0, 1, 5,  1, 0, 1};
    vt[14] = '{0, 0, 19, 1, 0, 0, 0, 0,  0, 0, 1};

    rst_n = 1'b0; join_en = 0; join_amt = '0; join_data = '0;
    pop_permit = 0; pop_amt = '0; flush = 0;
    repeat (3) @(negedge tb_sclk);
    check("rst level", level, 0);
    check("rst pop_en", pop_en, 0);
    check("rst pop_data", pop_data, 0);
    check("rst pop_count", pop_count, 0);
    check("rst permit", join_permit, 0);
    check("rst ovf", ovf_err, 0);
    rst_n = 1'b1;
    #1 check("permit before first edge", join_permit, 0);
    @(negedge tb_sclk);
    check("permit after release", join_permit, 1);

    for (int i = 0; i < 15; i++) begin
      drive_join(vt[i].jen ? vt[i].jamt : 0, 1);
      pop_amt = AMT_W'(vt[i].pamt); pop_permit = vt[i].pperm; flush = vt[i].fl;
      @(negedge tb_sclk);
      check($sformatf("tbl%0d level", i), level, vt[i].e_level);
      check($sformatf("tbl%0d pop_en", i), pop_en, vt[i].e_pe);
      check($sformatf("tbl%0d pop_count", i), pop_count, vt[i].e_cnt);
      check($sformatf("tbl%0d pop_last", i), pop_last, vt[i].e_last);
      check($sformatf("tbl%0d ovf", i), ovf_err, vt[i].e_ovf);
      check($sformatf("tbl%0d permit", i), join_permit, vt[i].e_permit);
    end
    flush = 0;

    pop_permit = 0;
    drive_join(32, 1); @(negedge tb_sclk);
    check("fill1 level", level, 32); check("fill1 permit", join_permit, 1);
    drive_join(32, 1); @(negedge tb_sclk);
    check("fill2 level", level, 64); check("fill2 permit", join_permit, 0);
    drive_join(32, 1); @(negedge tb_sclk);
    check("fill3 ovf", ovf_err, 0);
    drive_join(32, 1); @(negedge tb_sclk);
    check("full level", level, 128); check("full ovf", ovf_err, 0);
    check("full permit", join_permit, 0);

    drive_join(0, 0); pop_permit = 1; pop_amt = 6'd8; @(negedge tb_sclk);
    check("pop8 level", level, 120); check("pop8 count", pop_count, 8);
    pop_permit = 0; drive_join(10, 0); @(negedge tb_sclk);
    check("ovf pulse", ovf_err, 1); check("ovf level", level, 120);
    drive_join(0, 0); @(negedge tb_sclk);
    check("ovf cleared", ovf_err, 0); check("ovf level hold", level, 120);

    pop_permit = 1; pop_amt = 6'd32; @(negedge tb_sclk);
    pop_amt = 6'd11; @(negedge tb_sclk);
    pop_permit = 0;
    check("pre-reset level", level, 77); check("pre-reset pop_en", pop_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst level", level, 0); check("async rst pop_en", pop_en, 0);
    check("async rst pop_data", pop_data, 0); check("async rst permit", join_permit, 0);
    sb_q.delete();
    @(negedge tb_sclk); @(negedge tb_sclk);
    rst_n = 1'b1;
    @(negedge tb_sclk);
    check("re-release permit", join_permit, 1);

    flush = 1; @(negedge tb_sclk);
    flush = 0; @(negedge tb_sclk);
    drive_join(5, 1); pop_permit = 1; pop_amt = 6'd15; @(negedge tb_sclk);
    drive_join(0, 0); @(negedge tb_sclk); @(negedge tb_sclk);
    check("stale flush pop_en", pop_en, 0); check("stale flush level", level, 5);

    #1 pops0 = n_pops;
    ovf_seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (join_permit) drive_join(23, 1); else drive_join(0, 0);
      @(negedge tb_sclk);
      if (ovf_err) ovf_seen++;
    end
    drive_join(0, 0);
    waited = 0;
    while (level >= 15 && waited < 60) begin @(negedge tb_sclk); waited++; end
    check("stream drain bound", waited < 60, 1);
    flush = 1; @(negedge tb_sclk);
    flush = 0;
    waited = 0;
    while (level != 0 && waited < 10) begin @(negedge tb_sclk); waited++; end
    @(negedge tb_sclk); @(negedge tb_sclk);
    #1;
    check("stream level empty", level, 0);
    check("stream pop_en idle", pop_en, 0);
    check("stream ovf count", ovf_seen, 0);
    check("stream pops>=150", (n_pops - pops0) >= 150, 1);
    check("scoreboard empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
